// File: rtl/trojan_sweep_pkg.sv
// Shared types and defaults for the exhaustive pattern sweeper.
package trojan_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } sweep_state_e;

    localparam int DEFAULT_SIG_W = 16;
    localparam logic [DEFAULT_SIG_W-1:0] DEFAULT_MISR_POLY = 16'h1021;

endpackage

// File: rtl/sweep_misr.sv
// Serial-input MISR compacting the DUT response stream into a signature.
module sweep_misr
    import trojan_sweep_pkg::*;
#(
    parameter int               SIG_W = DEFAULT_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_MISR_POLY)
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] fb;

    assign fb = sig[SIG_W-1] ? POLY : '0;

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-1){1'b0}}, din};
        end
    end

endmodule

// File: rtl/trojan_pattern_sweeper.sv
// Walks every input pattern of a small DUT, captures each response and
// hands the response vector plus MISR signature off on valid/ready.
module trojan_pattern_sweeper
    import trojan_sweep_pkg::*;
#(
    parameter int               N_IN       = 4,
    parameter int               SETTLE_CYC = 1,
    parameter int               SIG_W      = DEFAULT_SIG_W,
    parameter logic [SIG_W-1:0] MISR_POLY  = SIG_W'(DEFAULT_MISR_POLY)
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    output logic [0:N_IN-1]      n_out,
    input  logic                 dut_resp,
    output logic                 busy,
    output logic [N_IN-1:0]      pattern_idx,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2**N_IN-1:0]   resp_vector,
    output logic [SIG_W-1:0]     signature
);

    localparam int NPAT  = 2**N_IN;
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [N_IN-1:0]  LAST_IDX = N_IN'(NPAT - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sweep_state_e     state;
    sweep_state_e     state_nx;
    logic [CNT_W-1:0] cnt;
    logic             launch;
    logic             sample;
    logic             last;

    assign last = (pattern_idx == LAST_IDX);

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        sample   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    launch   = 1'b1;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == CNT_ONE) begin
                    state_nx = SAMPLE;
                end
            end
            SAMPLE: begin
                sample   = 1'b1;
                state_nx = last ? DONE : SETTLE;
            end
            DONE: begin
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            pattern_idx <= '0;
            cnt         <= '0;
            resp_vector <= '0;
        end else if (launch) begin
            pattern_idx <= '0;
            cnt         <= CNT_LOAD;
            resp_vector <= '0;
        end else if (state == SETTLE) begin
            cnt <= cnt - CNT_ONE;
        end else if (sample) begin
            resp_vector[pattern_idx] <= dut_resp;
            // Last pattern stays applied; the sweep never wraps.
            if (!last) begin
                pattern_idx <= pattern_idx + 1'b1;
                cnt         <= CNT_LOAD;
            end
        end
    end

    sweep_misr #(
        .SIG_W (SIG_W),
        .POLY  (MISR_POLY)
    ) u_misr (
        .CK    (CK),
        .reset (reset),
        .clr   (launch),
        .en    (sample),
        .din   (dut_resp),
        .sig   (signature)
    );

    assign n_out      = pattern_idx;
    assign busy       = (state == SETTLE) || (state == SAMPLE);
    assign resp_valid = (state == DONE);

endmodule

// File: tb/tb_trojan_pattern_sweeper.sv
// Directed bench for the pattern sweeper with a modelled benchmark DUT
// and a queue of expected response vector / signature pairs.
module tb_trojan_pattern_sweeper;

    logic        CK = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        resp_ready = 1'b0;
    logic        dut_resp;
    logic [0:3]  n_out;
    logic        busy;
    logic [3:0]  pattern_idx;
    logic        resp_valid;
    logic [15:0] resp_vector;
    logic [15:0] signature;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    typedef struct packed {
        logic [15:0] vec;
        logic [15:0] sig;
    } exp_t;

    exp_t sb[$];

    trojan_pattern_sweeper dut (
        .CK          (CK),
        .reset       (reset),
        .start       (start),
        .n_out       (n_out),
        .dut_resp    (dut_resp),
        .busy        (busy),
        .pattern_idx (pattern_idx),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_vector (resp_vector),
        .signature   (signature)
    );

    always #5 CK = ~CK;

    function automatic logic resp_of(int m, logic [3:0] p);
        case (m)
            1:       return p == 4'd0;
            2:       return p == 4'd15;
            3:       return p == 4'd14;
            4:       return &p;
            default: return 1'b0;
        endcase
    endfunction

    assign dut_resp = resp_of(mode, n_out);

    function automatic exp_t model(int m);
        exp_t e;
        logic r;
        e = '0;
        for (int k = 0; k < 16; k++) begin
            r = resp_of(m, 4'(k));
            e.vec[k] = r;
            e.sig = {e.sig[14:0], 1'b0} ^ (e.sig[15] ? 16'h1021 : 16'h0000)
                    ^ {15'b0, r};
        end
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the phase 1 time unit after a rising edge, with the DUT idle.
    task automatic run_sweep(input int hold, input bit poke);
        exp_t e;
        int   c;
        int   idx;
        sb.push_back(model(mode));
        start = 1'b1;
        @(posedge CK); #1;
        start = 1'b0;
        c = 0;
        while (resp_valid !== 1'b1 && c < 40) begin
            if (poke) start = (c == 6);
            @(posedge CK); #1;
            c++;
            idx = (c / 2 > 15) ? 15 : c / 2;
            check("n_out", n_out, idx);
            check("pattern_idx", pattern_idx, idx);
            check("busy", busy, c < 32);
        end
        start = 1'b0;
        check("latency", c, 32);
        check("valid_rise", resp_valid, 1);
        check("sb_nonempty", sb.size() != 0, 1);
        e = (sb.size() != 0) ? sb.pop_front() : '1;
        check("resp_vector", resp_vector, e.vec);
        check("signature", signature, e.sig);
        repeat (hold) begin
            @(posedge CK); #1;
            check("hold_valid", resp_valid, 1);
            check("hold_vec", resp_vector, e.vec);
            check("hold_sig", signature, e.sig);
            check("hold_idx", pattern_idx, 15);
        end
        resp_ready = 1'b1;
        start = poke;
        @(posedge CK); #1;
        resp_ready = 1'b0;
        start = 1'b0;
        check("ack_valid", resp_valid, 0);
        check("ack_busy", busy, 0);
        check("kept_vec", resp_vector, e.vec);
        check("kept_sig", signature, e.sig);
        repeat (3) begin
            @(posedge CK); #1;
            check("idle_busy", busy, 0);
            check("idle_valid", resp_valid, 0);
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_n_out", n_out, 0);
        check("rst_idx", pattern_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_vec", resp_vector, 0);
        check("rst_sig", signature, 0);
        @(posedge CK); #1;
        reset = 1'b0;
        resp_ready = 1'b1;
        @(posedge CK); #1;
        check("ready_in_idle", busy, 0);
        resp_ready = 1'b0;

        mode = 0; run_sweep(0, 1'b0);
        mode = 1; run_sweep(0, 1'b0);
        mode = 2; run_sweep(0, 1'b0);
        mode = 3; run_sweep(0, 1'b0);
        mode = 4; run_sweep(5, 1'b0);

        mode = 1;
        start = 1'b1;
        @(posedge CK); #1;
        start = 1'b0;
        repeat (14) @(posedge CK);
        #1;
        check("abort_idx", pattern_idx, 7);
        check("abort_busy", busy, 1);
        check("abort_vec_pre", resp_vector, 16'h0001);
        #2 reset = 1'b1;
        #1;
        check("abort_n_out", n_out, 0);
        check("abort_idx0", pattern_idx, 0);
        check("abort_busy0", busy, 0);
        check("abort_valid0", resp_valid, 0);
        check("abort_vec0", resp_vector, 0);
        check("abort_sig0", signature, 0);
        #1 reset = 1'b0;
        @(posedge CK); #1;
        check("post_abort_idle", busy, 0);
        run_sweep(0, 1'b0);

        mode = 4; run_sweep(2, 1'b1);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
